// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: IFU and LSU request/response channels plus the shared memory port.
// The slave modport is the arbiter's view; the master modport is the view of the core and memory around it.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [AW-1:0]     ifu_addr;
  logic              ifu_resp_valid;
  logic [DW-1:0]     ifu_rdata;
  logic              ifu_resp_err;

  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic [AW-1:0]     lsu_addr;
  logic              lsu_wen;
  logic [DW-1:0]     lsu_wdata;
  logic [DW/8-1:0]   lsu_wmask;
  logic              lsu_resp_valid;
  logic [DW-1:0]     lsu_rdata;
  logic              lsu_resp_err;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [AW-1:0]     mem_addr;
  logic              mem_wen;
  logic [DW-1:0]     mem_wdata;
  logic [DW/8-1:0]   mem_wmask;
  logic              mem_resp_valid;
  logic [DW-1:0]     mem_rdata;
  logic              mem_resp_err;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between IFU and LSU, with a response timeout.
// Define ARB_RR_EN for round-robin arbitration; otherwise LSU has fixed priority over IFU.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);
  localparam int MW = DW / 8;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_e;

  state_e          state_q, state_d;
  logic            owner_lsu_q, owner_lsu_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            wen_q, wen_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [MW-1:0]   wmask_q, wmask_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            grant_lsu;
  logic            grant_ifu;
  logic            timeout_hit;
  logic            resp_fire;
  logic            resp_err;
  logic [DW-1:0]   resp_data;

`ifdef ARB_RR_EN
  logic rr_lsu_q, rr_lsu_d;

  // On a tie the pointer picks the winner; it flips to the loser after every accept.
  assign grant_lsu = bus.lsu_req_valid && (!bus.ifu_req_valid || rr_lsu_q);

  always_comb begin
    rr_lsu_d = rr_lsu_q;
    if (state_q == S_IDLE && (bus.lsu_req_valid || bus.ifu_req_valid)) begin
      rr_lsu_d = !grant_lsu;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_lsu_q <= 1'b1;
    end else begin
      rr_lsu_q <= rr_lsu_d;
    end
  end
`else
  assign grant_lsu = bus.lsu_req_valid;
`endif

  assign grant_ifu   = bus.ifu_req_valid && !grant_lsu;
  assign timeout_hit = (TIMEOUT > 0) && (cnt_q == CW'(TIMEOUT));

  always_comb begin
    state_d           = state_q;
    owner_lsu_d       = owner_lsu_q;
    addr_d            = addr_q;
    wen_d             = wen_q;
    wdata_d           = wdata_q;
    wmask_d           = wmask_q;
    cnt_d             = cnt_q;
    bus.ifu_req_ready = 1'b0;
    bus.lsu_req_ready = 1'b0;
    bus.mem_req_valid = 1'b0;
    resp_fire         = 1'b0;
    resp_err          = 1'b0;
    resp_data         = '0;
    unique case (state_q)
      S_IDLE: begin
        bus.lsu_req_ready = grant_lsu;
        bus.ifu_req_ready = grant_ifu;
        if (grant_lsu) begin
          owner_lsu_d = 1'b1;
          addr_d      = bus.lsu_addr;
          wen_d       = bus.lsu_wen;
          wdata_d     = bus.lsu_wdata;
          wmask_d     = bus.lsu_wmask;
          state_d     = S_REQ;
        end else if (grant_ifu) begin
          owner_lsu_d = 1'b0;
          addr_d      = bus.ifu_addr;
          wen_d       = 1'b0;
          wdata_d     = '0;
          wmask_d     = '1;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        bus.mem_req_valid = 1'b1;
        if (bus.mem_req_ready) begin
          cnt_d   = '0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        // A real response in the same cycle as the limit still wins over the timeout.
        if (bus.mem_resp_valid) begin
          resp_fire = 1'b1;
          resp_err  = bus.mem_resp_err;
          resp_data = bus.mem_rdata;
          state_d   = S_IDLE;
        end else if (timeout_hit) begin
          resp_fire = 1'b1;
          resp_err  = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.ifu_resp_valid = resp_fire && !owner_lsu_q;
  assign bus.ifu_resp_err   = resp_err && !owner_lsu_q;
  assign bus.ifu_rdata      = owner_lsu_q ? '0 : resp_data;
  assign bus.lsu_resp_valid = resp_fire && owner_lsu_q;
  assign bus.lsu_resp_err   = resp_err && owner_lsu_q;
  assign bus.lsu_rdata      = owner_lsu_q ? resp_data : '0;

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wen   = wen_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wmask = wmask_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      owner_lsu_q <= 1'b0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      owner_lsu_q <= owner_lsu_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      cnt_q       <= cnt_d;
    end
  end
endmodule
